// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_divider                                                     |
// | Purpose  : Unsigned restoring divider, one quotient bit per clock.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seq_divider #(
  parameter int BIT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIT_DEPTH-1:0] dividend,
  input  logic [BIT_DEPTH-1:0] divisor,
  output logic [BIT_DEPTH-1:0] quotient,
  output logic [BIT_DEPTH-1:0] remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero
);

  localparam int                 c_CNT_W     = $clog2(BIT_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(BIT_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIT_DEPTH-1:0] rem_q, rem_d;
  logic [BIT_DEPTH-1:0] quo_q, quo_d;
  logic [BIT_DEPTH-1:0] dvs_q, dvs_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 dbz_q, dbz_d;

  logic                 w_accept;
  logic [BIT_DEPTH:0]   w_rem_shift;
  logic [BIT_DEPTH:0]   w_trial;

  // Since rem_q < dvs_q, the shifted value is below 2*dvs_q, so BIT_DEPTH+1
  // bits hold it and the trial MSB is a true sign bit.
  assign w_rem_shift = {rem_q, quo_q[BIT_DEPTH-1]};
  assign w_trial     = w_rem_shift - {1'b0, dvs_q};
  assign w_accept    = start && (state_q != S_RUN);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_RUN: begin
        rem_d = w_trial[BIT_DEPTH] ? w_rem_shift[BIT_DEPTH-1:0] : w_trial[BIT_DEPTH-1:0];
        quo_d = {quo_q[BIT_DEPTH-2:0], ~w_trial[BIT_DEPTH]};
        cnt_d = cnt_q + c_CNT_W'(1);
        if (cnt_q == c_LAST_STEP) begin
          state_d = S_DONE;
        end
      end
      default: begin
        if (w_accept) begin
          cnt_d = '0;
          dvs_d = divisor;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            quo_d   = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = done ? quo_q : '0;
  assign remainder   = done ? rem_q : '0;
  assign div_by_zero = done & dbz_q;

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001: Parameter BIT_DEPTH, default 4, operand width; legal values 2..16.
REQ-002: The block SHALL use one clock; reset is synchronous and active-high.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: reset  input  1  synchronous active-high reset.
REQ-005: start  input  1  request to begin a division; sampled on clk rising edge.
REQ-006: dividend  input  BIT_DEPTH  unsigned numerator, captured when start is accepted.
REQ-007: divisor  input  BIT_DEPTH  unsigned denominator, captured when start is accepted.
REQ-008: quotient  output  BIT_DEPTH  unsigned result; zero unless done=1.
REQ-009: remainder  output  BIT_DEPTH  unsigned result; zero unless done=1.
REQ-010: busy  output  1  high while an iteration sequence is in progress.
REQ-011: done  output  1  high while results are valid.
REQ-012: div_by_zero  output  1  high with done when the captured divisor was 0.

Function
REQ-013: The block SHALL implement a three-state FSM: IDLE, RUN, DONE; busy=1 only in RUN and done=1 only in DONE.
REQ-014: The block SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on operands, counter or state.
REQ-015: On accepted start with divisor!=0, the block SHALL load remainder register=0, quotient register=dividend, divisor register=divisor, counter=0, and enter RUN.
REQ-016: Each RUN cycle SHALL perform one restoring step: shift {R,Q} left by 1; form trial = R_shifted - D at BIT_DEPTH+1 bits; if trial is non-negative, R=trial and Q[0]=1, else R is unchanged and Q[0]=0.
REQ-017: The counter SHALL increment once per RUN cycle; after exactly BIT_DEPTH steps the FSM SHALL enter DONE.
REQ-018: Latency: with start high in cycle k, done SHALL be high from cycle k+BIT_DEPTH+1, i.e. after BIT_DEPTH+1 rising edges.
REQ-019: In DONE, quotient and remainder SHALL hold floor(dividend/divisor) and dividend mod divisor until the next accepted start or reset.
REQ-020: On accepted start with divisor=0, the block SHALL bypass RUN and enter DONE on the next edge with quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-021: div_by_zero SHALL be 0 in IDLE, RUN, and DONE for nonzero divisor.
REQ-022: start asserted in DONE SHALL be accepted on that edge; done SHALL drop the following cycle, with no gap cycle required.
REQ-023: Internal arithmetic SHALL never overflow; the remainder SHALL always be < divisor at DONE.
REQ-024: Operand inputs changing after acceptance SHALL not affect the result in progress.

Reset
REQ-025: reset=1 at a rising edge SHALL force IDLE, clear all registers and counter, and drive quotient=0, remainder=0, busy=0, done=0, div_by_zero=0 from the next cycle.
REQ-026: reset SHALL take priority over start in the same cycle, and SHALL abort any RUN or DONE without producing a result.
REQ-027: After reset deasserts, the block SHALL accept start on the first following edge.

Verification
REQ-028: dividend=13, divisor=4, start 1 cycle -> busy for 4 cycles, then done=1, quotient=3, remainder=1, div_by_zero=0.
REQ-029: dividend=15, divisor=1 -> quotient=15, remainder=0; dividend=3, divisor=9 -> quotient=0, remainder=3.
REQ-030: dividend=7, divisor=0 -> done=1 one edge after start, quotient=15, remainder=7, div_by_zero=1, busy never high.
REQ-031: 12/5 started, reset pulsed at RUN step 2 -> all outputs 0, IDLE; a new 9/2 start gives quotient=4, remainder=1.
REQ-032: 14/3 started, start re-pulsed with 6/6 during RUN -> ignored; result quotient=4, remainder=2; start in DONE with 6/6 -> quotient=1, remainder=0.
REQ-033: For BIT_DEPTH=4, exhaustive sweep of all 256 operand pairs with a reference model -> every result and div_by_zero matches; latency is exactly BIT_DEPTH+1 edges for nonzero divisor.
